// File: rtl/rr_reg_arbiter_if.sv
// Requester/arbiter bundle for rr_reg_arbiter: request, lock and data in; grant and shared register out.
interface rr_reg_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8
);
  localparam int IW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]        req_i;
  logic [NUM_REQ-1:0]        lock_i;
  logic [NUM_REQ*DATA_W-1:0] data_i;
  logic [NUM_REQ-1:0]        gnt_o;
  logic [IW-1:0]             gnt_id_o;
  logic [DATA_W-1:0]         q_o;
  logic                      q_valid_o;
  logic                      busy_o;

  modport master (
    output req_i, lock_i, data_i,
    input  gnt_o, gnt_id_o, q_o, q_valid_o, busy_o
  );

  modport slave (
    input  req_i, lock_i, data_i,
    output gnt_o, gnt_id_o, q_o, q_valid_o, busy_o
  );
endinterface

// File: rtl/rr_reg_arbiter.sv
// Round-robin arbiter owning one shared capture register; a locked winner may keep
// the grant for up to MAX_LOCK consecutive cycles before it is forced to release.
module rr_reg_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int DATA_W   = 8,
  parameter int MAX_LOCK = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  rr_reg_arbiter_if.slave  bus
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(MAX_LOCK + 1);
  localparam logic [CW-1:0] MAX_C = CW'(MAX_LOCK);
  localparam logic [IW-1:0] LAST  = IW'(NUM_REQ - 1);

  typedef enum logic [1:0] {IDLE, GRANT, LOCK} state_e;

  state_e                          state_q, state_d;
  logic [IW-1:0]                   ptr_q, ptr_d;
  logic [CW-1:0]                   cnt_q, cnt_d;
  logic [NUM_REQ-1:0]              gnt_q, gnt_d;
  logic [IW-1:0]                   id_q, id_d;
  logic [DATA_W-1:0]               q_q, q_d;
  logic                            vld_q, vld_d;

  logic [NUM_REQ-1:0][DATA_W-1:0]  data_arr;
  logic [IW:0]                     scan_idx;
  logic [IW-1:0]                   win;
  logic                            any_req;
  logic                            hold;

  assign data_arr = bus.data_i;
  assign any_req  = |bus.req_i;
  assign hold     = (state_q == LOCK) && bus.req_i[id_q] && bus.lock_i[id_q] && (cnt_q < MAX_C);

  // Scan from the highest offset down so the last hit is the first requester at or after ptr.
  always_comb begin
    win      = '0;
    scan_idx = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      scan_idx = {1'b0, ptr_q} + (IW + 1)'(i);
      if (scan_idx >= (IW + 1)'(NUM_REQ)) scan_idx = scan_idx - (IW + 1)'(NUM_REQ);
      if (bus.req_i[scan_idx[IW-1:0]]) win = scan_idx[IW-1:0];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = IDLE;
    if (hold)         state_d = LOCK;
    else if (any_req) state_d = bus.lock_i[win] ? LOCK : GRANT;
  end

  // Release (voluntary or forced) falls straight into a fresh arbitration, so there is no bubble.
  always_comb begin
    ptr_d = ptr_q;
    cnt_d = '0;
    gnt_d = '0;
    id_d  = id_q;
    q_d   = q_q;
    vld_d = 1'b0;
    if (hold) begin
      cnt_d = cnt_q + CW'(1);
      gnt_d = gnt_q;
      q_d   = data_arr[id_q];
      vld_d = 1'b1;
    end else if (any_req) begin
      gnt_d[win] = 1'b1;
      id_d       = win;
      q_d        = data_arr[win];
      vld_d      = 1'b1;
      ptr_d      = (win == LAST) ? '0 : win + IW'(1);
      cnt_d      = bus.lock_i[win] ? CW'(1) : '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= '0;
      cnt_q <= '0;
      gnt_q <= '0;
      id_q  <= '0;
      q_q   <= '0;
      vld_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
      gnt_q <= gnt_d;
      id_q  <= id_d;
      q_q   <= q_d;
      vld_q <= vld_d;
    end
  end

  assign bus.gnt_o     = gnt_q;
  assign bus.gnt_id_o  = id_q;
  assign bus.q_o       = q_q;
  assign bus.q_valid_o = vld_q;
  assign bus.busy_o    = (state_q == LOCK);
endmodule

// File: tb/tb_rr_reg_arbiter.sv
// Scoreboard bench: each stimulus step pushes its expected outputs, which are popped and
// compared one edge later; a second instance with MAX_LOCK=4 covers forced release.
module tb_rr_reg_arbiter;
  typedef struct packed {
    logic [3:0] gnt;
    logic [1:0] id;
    logic [7:0] q;
    logic       vld;
    logic       busy;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  exp_t sb_a[$];
  exp_t sb_b[$];

  always #5 clk = ~clk;

  rr_reg_arbiter_if #(.NUM_REQ(4), .DATA_W(8)) ifa ();
  rr_reg_arbiter_if #(.NUM_REQ(4), .DATA_W(8)) ifb ();

  rr_reg_arbiter #(.NUM_REQ(4), .DATA_W(8), .MAX_LOCK(16)) u_dut (
    .clk_i(clk), .rst_ni(rst_n), .bus(ifa.slave));
  rr_reg_arbiter #(.NUM_REQ(4), .DATA_W(8), .MAX_LOCK(4)) u_dut4 (
    .clk_i(clk), .rst_ni(rst_n), .bus(ifb.slave));

  function automatic exp_t obs_a();
    return {ifa.gnt_o, ifa.gnt_id_o, ifa.q_o, ifa.q_valid_o, ifa.busy_o};
  endfunction

  function automatic exp_t obs_b();
    return {ifb.gnt_o, ifb.gnt_id_o, ifb.q_o, ifb.q_valid_o, ifb.busy_o};
  endfunction

  function automatic exp_t mk(input logic [3:0] gnt, input logic [1:0] id,
                              input logic [7:0] q, input logic vld, input logic busy);
    return {gnt, id, q, vld, busy};
  endfunction

  // Drive one step, record what should appear after the next edge, then wait for it.
  task automatic step_a(input logic [3:0] req, input logic [3:0] lock, input exp_t e);
    ifa.req_i  = req;
    ifa.lock_i = lock;
    sb_a.push_back(e);
    @(posedge clk); #1;
  endtask

  task automatic step_b(input logic [3:0] req, input logic [3:0] lock, input exp_t e);
    ifb.req_i  = req;
    ifb.lock_i = lock;
    sb_b.push_back(e);
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    exp_t e, o;
    #3;
    sb_a.push_back('0);
    sb_b.push_back('0);
    e = sb_a.pop_front(); o = obs_a(); checks++;
    if (o !== e) begin errors++; $display("FAIL reset_a: got %h want %h", o, e); end
    e = sb_b.pop_front(); o = obs_b(); checks++;
    if (o !== e) begin errors++; $display("FAIL reset_b: got %h want %h", o, e); end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_fairness();
    exp_t e, o;
    for (int i = 0; i < 5; i++) begin
      step_a(4'b1111, 4'b0000,
             mk(4'b0001 << (i % 4), 2'(i % 4), 8'h10 + 8'(i % 4), 1'b1, 1'b0));
      e = sb_a.pop_front(); o = obs_a(); checks++;
      if (o !== e) begin errors++; $display("FAIL fairness[%0d]: got %h want %h", i, o, e); end
    end
  endtask

  task automatic test_wrap();
    exp_t e, o;
    for (int i = 0; i < 3; i++) begin
      step_a(4'b1000, 4'b0000, mk(4'b1000, 2'd3, 8'h13, 1'b1, 1'b0));
      e = sb_a.pop_front(); o = obs_a(); checks++;
      if (o !== e) begin errors++; $display("FAIL sole_req[%0d]: got %h want %h", i, o, e); end
    end
    // Both 0 and 3 request: 0 must win only if the pointer wrapped to 0.
    step_a(4'b1001, 4'b0000, mk(4'b0001, 2'd0, 8'h10, 1'b1, 1'b0));
    e = sb_a.pop_front(); o = obs_a(); checks++;
    if (o !== e) begin errors++; $display("FAIL ptr_wrap: got %h want %h", o, e); end
  endtask

  task automatic test_no_req();
    exp_t e, o;
    for (int i = 0; i < 2; i++) begin
      step_a(4'b0000, 4'b0000, mk(4'b0000, 2'd0, 8'h10, 1'b0, 1'b0));
      e = sb_a.pop_front(); o = obs_a(); checks++;
      if (o !== e) begin errors++; $display("FAIL no_req[%0d]: got %h want %h", i, o, e); end
    end
  endtask

  task automatic test_lock_release();
    exp_t e, o;
    step_a(4'b1000, 4'b0000, mk(4'b1000, 2'd3, 8'h13, 1'b1, 1'b0));
    e = sb_a.pop_front(); o = obs_a(); checks++;
    if (o !== e) begin errors++; $display("FAIL lock_setup: got %h want %h", o, e); end
    for (int i = 0; i < 3; i++) begin
      step_a(4'b0011, 4'b0001, mk(4'b0001, 2'd0, 8'h10, 1'b1, 1'b1));
      e = sb_a.pop_front(); o = obs_a(); checks++;
      if (o !== e) begin errors++; $display("FAIL lock_hold[%0d]: got %h want %h", i, o, e); end
    end
    step_a(4'b0011, 4'b0000, mk(4'b0010, 2'd1, 8'h11, 1'b1, 1'b0));
    e = sb_a.pop_front(); o = obs_a(); checks++;
    if (o !== e) begin errors++; $display("FAIL lock_release: got %h want %h", o, e); end
    // lock_i[3] without req_i[3] must not turn requester 2's grant into a lock.
    step_a(4'b0100, 4'b1000, mk(4'b0100, 2'd2, 8'h12, 1'b1, 1'b0));
    e = sb_a.pop_front(); o = obs_a(); checks++;
    if (o !== e) begin errors++; $display("FAIL stray_lock: got %h want %h", o, e); end
  endtask

  task automatic test_forced_release();
    exp_t e, o;
    for (int i = 0; i < 4; i++) begin
      step_b(4'b0011, 4'b0001, mk(4'b0001, 2'd0, 8'h10, 1'b1, 1'b1));
      e = sb_b.pop_front(); o = obs_b(); checks++;
      if (o !== e) begin errors++; $display("FAIL forced_hold[%0d]: got %h want %h", i, o, e); end
    end
    step_b(4'b0011, 4'b0001, mk(4'b0010, 2'd1, 8'h11, 1'b1, 1'b0));
    e = sb_b.pop_front(); o = obs_b(); checks++;
    if (o !== e) begin errors++; $display("FAIL forced_release: got %h want %h", o, e); end
    step_b(4'b0011, 4'b0001, mk(4'b0001, 2'd0, 8'h10, 1'b1, 1'b1));
    e = sb_b.pop_front(); o = obs_b(); checks++;
    if (o !== e) begin errors++; $display("FAIL relock: got %h want %h", o, e); end
    ifb.req_i  = '0;
    ifb.lock_i = '0;
  endtask

  task automatic test_reset_midlock();
    exp_t e, o;
    for (int i = 0; i < 2; i++) begin
      step_a(4'b0001, 4'b0001, mk(4'b0001, 2'd0, 8'h10, 1'b1, 1'b1));
      e = sb_a.pop_front(); o = obs_a(); checks++;
      if (o !== e) begin errors++; $display("FAIL midlock_setup[%0d]: got %h want %h", i, o, e); end
    end
    #2 rst_n = 1'b0;
    #1;
    sb_a.push_back('0);
    e = sb_a.pop_front(); o = obs_a(); checks++;
    if (o !== e) begin errors++; $display("FAIL async_reset: got %h want %h", o, e); end
    ifa.lock_i = '0;
    ifa.req_i  = 4'b0100;
    sb_a.push_back(mk(4'b0100, 2'd2, 8'h12, 1'b1, 1'b0));
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    e = sb_a.pop_front(); o = obs_a(); checks++;
    if (o !== e) begin errors++; $display("FAIL after_reset: got %h want %h", o, e); end
  endtask

  initial begin
    ifa.req_i  = '0;
    ifa.lock_i = '0;
    ifa.data_i = {8'h13, 8'h12, 8'h11, 8'h10};
    ifb.req_i  = '0;
    ifb.lock_i = '0;
    ifb.data_i = {8'h13, 8'h12, 8'h11, 8'h10};
    test_reset();
    test_fairness();
    test_wrap();
    test_no_req();
    test_lock_release();
    test_forced_release();
    test_reset_midlock();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
